// File: rtl/xike_pkg.sv
// rtl/xike_pkg.sv - shared types and defaults for the Xike bank frame counters
// Contents: recording state enum, default parameter values.
package xike_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int NUM_CH_DEF = 32;
  localparam int CH_W_DEF   = 8;
  localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/frame_stamp_counter_if.sv
// rtl/frame_stamp_counter_if.sv - channel, control and snapshot bundle of frame_stamp_counter
// master: drives ch_idx/ch_valid, rec_start/rec_stop, snap_req/snap_ready; observes counter outputs.
// slave : the counter; drives frame_No, frame_tick, recording, overflow, snap_data, snap_valid.
interface frame_stamp_counter_if
  import xike_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [CH_W-1:0]  ch_idx;
  logic             ch_valid;
  logic             rec_start;
  logic             rec_stop;
  logic             snap_req;
  logic             snap_ready;
  logic [CNT_W-1:0] frame_No;
  logic             frame_tick;
  logic             recording;
  logic             overflow;
  logic [CNT_W-1:0] snap_data;
  logic             snap_valid;

  modport master (
    output ch_idx, ch_valid, rec_start, rec_stop, snap_req, snap_ready,
    input  frame_No, frame_tick, recording, overflow, snap_data, snap_valid
  );

  modport slave (
    input  ch_idx, ch_valid, rec_start, rec_stop, snap_req, snap_ready,
    output frame_No, frame_tick, recording, overflow, snap_data, snap_valid
  );

endinterface

// File: rtl/frame_edge_detect.sv
// rtl/frame_edge_detect.sv - single-cycle frame boundary pulse from a channel index stream
// Ports: clk, rst (sync active-high), ch_idx/ch_valid (index stream),
//        boundary (high on the first cycle the index equals NUM_CH).
module frame_edge_detect
  import xike_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_W-1:0] ch_idx,
  input  logic            ch_valid,
  output logic            boundary
);

  localparam logic [CH_W-1:0] END_IDX = CH_W'(NUM_CH);

  logic match;
  logic match_d;
  logic match_q;

  assign match   = ch_valid && (ch_idx == END_IDX);
  assign match_d = match;

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  // Rising edge of match: an index held for several cycles yields one boundary.
  assign boundary = match && !match_q;

endmodule

// File: rtl/frame_stamp_counter.sv
// rtl/frame_stamp_counter.sv - record-window frame counter with wrap flag and snapshot port
// Ports: clk, rst (sync active-high), bus (slave modport): channel index stream,
//        rec_start/rec_stop pulses, snap_req/snap_ready handshake, live count,
//        frame_tick, recording, overflow, snap_data/snap_valid. All outputs registered.
module frame_stamp_counter
  import xike_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = CH_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_stamp_counter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_no_q, frame_no_d;
  logic             tick_q, tick_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] snap_data_q, snap_data_d;
  logic             snap_valid_q, snap_valid_d;
  logic             boundary;

  frame_edge_detect #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_edge (
    .clk      (clk),
    .rst      (rst),
    .ch_idx   (bus.ch_idx),
    .ch_valid (bus.ch_valid),
    .boundary (boundary)
  );

  always_comb begin
    state_d      = state_q;
    frame_no_d   = frame_no_q;
    tick_d       = 1'b0;
    ovf_d        = ovf_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;

    // Stop beats start beats boundary; stop never clears the count.
    if (bus.rec_stop) begin
      state_d = ST_IDLE;
    end else if (bus.rec_start) begin
      state_d    = ST_ARMED;
      frame_no_d = '0;
      ovf_d      = 1'b0;
    end else if (boundary) begin
      case (state_q)
        ST_ARMED: state_d = ST_RUN;
        ST_RUN: begin
          frame_no_d = frame_no_q + CNT_W'(1);
          tick_d     = 1'b1;
          if (frame_no_q == '1) ovf_d = 1'b1;
        end
        default: ;
      endcase
    end

    // Capture uses the pre-increment count; requests are ignored while a
    // snapshot is pending, including in the cycle it is accepted.
    if (snap_valid_q) begin
      if (bus.snap_ready) snap_valid_d = 1'b0;
    end else if (bus.snap_req) begin
      snap_data_d  = frame_no_q;
      snap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_no_q   <= '0;
      tick_q       <= 1'b0;
      ovf_q        <= 1'b0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_no_q   <= frame_no_d;
      tick_q       <= tick_d;
      ovf_q        <= ovf_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign bus.frame_No   = frame_no_q;
  assign bus.frame_tick = tick_q;
  assign bus.recording  = (state_q != ST_IDLE);
  assign bus.overflow   = ovf_q;
  assign bus.snap_data  = snap_data_q;
  assign bus.snap_valid = snap_valid_q;

endmodule

// File: tb/tb_frame_stamp_counter.sv
// tb/tb_frame_stamp_counter.sv - directed self-checking bench for frame_stamp_counter
module tb_frame_stamp_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ch_idx_r;
  logic       ch_valid_r, rec_start_r, rec_stop_r, snap_req_r, snap_ready_r;

  int total = 0;
  int bad   = 0;
  int ticks = 0;

  always #5 clk = ~clk;

  frame_stamp_counter_if #(.CH_W(8), .CNT_W(32)) bus ();
  frame_stamp_counter_if #(.CH_W(8), .CNT_W(4))  bus_w ();

  assign bus.ch_idx       = ch_idx_r;
  assign bus.ch_valid     = ch_valid_r;
  assign bus.rec_start    = rec_start_r;
  assign bus.rec_stop     = rec_stop_r;
  assign bus.snap_req     = snap_req_r;
  assign bus.snap_ready   = snap_ready_r;
  assign bus_w.ch_idx     = ch_idx_r;
  assign bus_w.ch_valid   = ch_valid_r;
  assign bus_w.rec_start  = rec_start_r;
  assign bus_w.rec_stop   = rec_stop_r;
  assign bus_w.snap_req   = snap_req_r;
  assign bus_w.snap_ready = snap_ready_r;

  frame_stamp_counter #(.NUM_CH(32), .CH_W(8), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_stamp_counter #(.NUM_CH(32), .CH_W(8), .CNT_W(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  always @(negedge clk) if (bus.frame_tick === 1'b1) ticks <= ticks + 1;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: index at NUM_CH for 'hold' cycles, then one non-matching cycle.
  task automatic frame(input int hold);
    ch_valid_r = 1'b1;
    ch_idx_r   = 8'd32;
    step(hold);
    ch_idx_r   = 8'd0;
    step(1);
  endtask

  task automatic pulse_start();
    rec_start_r = 1'b1;
    step(1);
    rec_start_r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    total++; if (bus.frame_No   !== 32'd0) begin bad++; $display("FAIL reset_frame_No got=%0d exp=0", bus.frame_No); end
    total++; if (bus.frame_tick !== 1'b0)  begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.frame_tick); end
    total++; if (bus.recording  !== 1'b0)  begin bad++; $display("FAIL reset_recording got=%b exp=0", bus.recording); end
    total++; if (bus.overflow   !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    total++; if (bus.snap_valid !== 1'b0)  begin bad++; $display("FAIL reset_snap_valid got=%b exp=0", bus.snap_valid); end
    total++; if (bus.snap_data  !== 32'd0) begin bad++; $display("FAIL reset_snap_data got=%0d exp=0", bus.snap_data); end
  endtask

  task automatic test_idle();
    int t0 = ticks;
    ch_valid_r = 1'b1;
    ch_idx_r   = 8'd32;
    step(10);
    ch_idx_r   = 8'd0;
    step(1);
    total++; if (bus.frame_No  !== 32'd0) begin bad++; $display("FAIL idle_frame_No got=%0d exp=0", bus.frame_No); end
    total++; if (ticks - t0    !== 0)     begin bad++; $display("FAIL idle_ticks got=%0d exp=0", ticks - t0); end
    total++; if (bus.recording !== 1'b0)  begin bad++; $display("FAIL idle_recording got=%b exp=0", bus.recording); end
  endtask

  task automatic test_align_hold();
    int t0 = ticks;
    pulse_start();
    total++; if (bus.recording !== 1'b1) begin bad++; $display("FAIL armed_recording got=%b exp=1", bus.recording); end
    frame(4);
    total++; if (bus.frame_No !== 32'd0) begin bad++; $display("FAIL align_first_frame got=%0d exp=0", bus.frame_No); end
    frame(4);
    frame(4);
    total++; if (bus.frame_No !== 32'd2) begin bad++; $display("FAIL align_frame_No got=%0d exp=2", bus.frame_No); end
    total++; if (ticks - t0   !== 2)     begin bad++; $display("FAIL align_ticks got=%0d exp=2", ticks - t0); end
  endtask

  task automatic test_stop_priority();
    frame(1);
    frame(1);
    frame(1);
    total++; if (bus.frame_No !== 32'd5) begin bad++; $display("FAIL stop_pre_count got=%0d exp=5", bus.frame_No); end
    ch_idx_r   = 8'd32;
    rec_stop_r = 1'b1;
    step(1);
    rec_stop_r = 1'b0;
    ch_idx_r   = 8'd0;
    total++; if (bus.frame_No   !== 32'd5) begin bad++; $display("FAIL stop_frame_No got=%0d exp=5", bus.frame_No); end
    total++; if (bus.frame_tick !== 1'b0)  begin bad++; $display("FAIL stop_tick got=%b exp=0", bus.frame_tick); end
    total++; if (bus.recording  !== 1'b0)  begin bad++; $display("FAIL stop_recording got=%b exp=0", bus.recording); end
    step(1);
    pulse_start();
    total++; if (bus.frame_No !== 32'd0) begin bad++; $display("FAIL restart_clear got=%0d exp=0", bus.frame_No); end
    frame(1);
    frame(1);
    rec_start_r = 1'b1;
    rec_stop_r  = 1'b1;
    step(1);
    rec_start_r = 1'b0;
    rec_stop_r  = 1'b0;
    total++; if (bus.frame_No  !== 32'd1) begin bad++; $display("FAIL start_stop_count got=%0d exp=1", bus.frame_No); end
    total++; if (bus.recording !== 1'b0)  begin bad++; $display("FAIL start_stop_recording got=%b exp=0", bus.recording); end
  endtask

  task automatic test_wrap();
    pulse_start();
    frame(1);
    for (int i = 0; i < 15; i++) frame(2);
    total++; if (bus_w.frame_No !== 4'd15) begin bad++; $display("FAIL wrap_pre_count got=%0d exp=15", bus_w.frame_No); end
    total++; if (bus_w.overflow !== 1'b0)  begin bad++; $display("FAIL wrap_pre_overflow got=%b exp=0", bus_w.overflow); end
    ch_idx_r = 8'd32;
    step(1);
    total++; if (bus_w.frame_No   !== 4'd0) begin bad++; $display("FAIL wrap_frame_No got=%0d exp=0", bus_w.frame_No); end
    total++; if (bus_w.frame_tick !== 1'b1) begin bad++; $display("FAIL wrap_tick got=%b exp=1", bus_w.frame_tick); end
    total++; if (bus_w.overflow   !== 1'b1) begin bad++; $display("FAIL wrap_overflow got=%b exp=1", bus_w.overflow); end
    total++; if (bus.frame_No     !== 32'd16) begin bad++; $display("FAIL wide_no_wrap got=%0d exp=16", bus.frame_No); end
    ch_idx_r = 8'd0;
    step(1);
    frame(1);
    total++; if (bus_w.overflow !== 1'b1) begin bad++; $display("FAIL wrap_sticky got=%b exp=1", bus_w.overflow); end
    pulse_start();
    total++; if (bus_w.overflow !== 1'b0) begin bad++; $display("FAIL wrap_clear got=%b exp=0", bus_w.overflow); end
    total++; if (bus_w.frame_No !== 4'd0) begin bad++; $display("FAIL wrap_clear_count got=%0d exp=0", bus_w.frame_No); end
  endtask

  task automatic test_snapshot();
    frame(1);
    for (int i = 0; i < 7; i++) frame(1);
    ch_idx_r   = 8'd32;
    snap_req_r = 1'b1;
    step(1);
    snap_req_r = 1'b0;
    ch_idx_r   = 8'd0;
    total++; if (bus.snap_data  !== 32'd7) begin bad++; $display("FAIL snap_data got=%0d exp=7", bus.snap_data); end
    total++; if (bus.snap_valid !== 1'b1)  begin bad++; $display("FAIL snap_valid got=%b exp=1", bus.snap_valid); end
    total++; if (bus.frame_No   !== 32'd8) begin bad++; $display("FAIL snap_frame_No got=%0d exp=8", bus.frame_No); end
    step(1);
    snap_req_r = 1'b1;
    step(1);
    total++; if (bus.snap_data  !== 32'd7) begin bad++; $display("FAIL snap_ignored_data got=%0d exp=7", bus.snap_data); end
    total++; if (bus.snap_valid !== 1'b1)  begin bad++; $display("FAIL snap_held got=%b exp=1", bus.snap_valid); end
    snap_ready_r = 1'b1;
    step(1);
    snap_req_r   = 1'b0;
    snap_ready_r = 1'b0;
    total++; if (bus.snap_valid !== 1'b0)  begin bad++; $display("FAIL snap_accept got=%b exp=0", bus.snap_valid); end
    step(1);
    total++; if (bus.snap_valid !== 1'b0)  begin bad++; $display("FAIL snap_accept_req_ignored got=%b exp=0", bus.snap_valid); end
  endtask

  task automatic test_reset_mid();
    frame(1);
    snap_req_r = 1'b1;
    step(1);
    snap_req_r = 1'b0;
    total++; if (bus.snap_data !== 32'd9) begin bad++; $display("FAIL mid_snap_data got=%0d exp=9", bus.snap_data); end
    total++; if (bus.recording !== 1'b1)  begin bad++; $display("FAIL mid_recording got=%b exp=1", bus.recording); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total++; if (bus.frame_No   !== 32'd0) begin bad++; $display("FAIL mid_rst_frame_No got=%0d exp=0", bus.frame_No); end
    total++; if (bus.recording  !== 1'b0)  begin bad++; $display("FAIL mid_rst_recording got=%b exp=0", bus.recording); end
    total++; if (bus.snap_valid !== 1'b0)  begin bad++; $display("FAIL mid_rst_snap_valid got=%b exp=0", bus.snap_valid); end
    total++; if (bus.snap_data  !== 32'd0) begin bad++; $display("FAIL mid_rst_snap_data got=%0d exp=0", bus.snap_data); end
    total++; if (bus.overflow   !== 1'b0)  begin bad++; $display("FAIL mid_rst_overflow got=%b exp=0", bus.overflow); end
    total++; if (bus.frame_tick !== 1'b0)  begin bad++; $display("FAIL mid_rst_tick got=%b exp=0", bus.frame_tick); end
  endtask

  initial begin
    rst          = 1'b1;
    ch_idx_r     = 8'd0;
    ch_valid_r   = 1'b0;
    rec_start_r  = 1'b0;
    rec_stop_r   = 1'b0;
    snap_req_r   = 1'b0;
    snap_ready_r = 1'b0;
    #2;
    test_reset();
    test_idle();
    test_align_hold();
    test_stop_priority();
    test_wrap();
    test_snapshot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
